// File: rtl/nios_hex_bank.sv
// nios_hex_bank: multi-digit seven-segment output peripheral on an Avalon-MM slave.
// Holds NUM_DIGITS digit registers with optional hex decode, per-digit blink,
// output inversion and a shift-in register for scrolling text.
module nios_hex_bank #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_W-1:0]       address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [8*NUM_DIGITS-1:0] out_port
);

  localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic                    wr;
  logic [2:0]              ctrl_q, ctrl_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [7:0]              digit_q [NUM_DIGITS];
  logic [7:0]              digit_d [NUM_DIGITS];
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    phase_q, phase_d;
  logic [8*NUM_DIGITS-1:0] out_q, out_d;
  logic                    unused_wd;

  assign wr        = chipselect & ~write_n;
  assign unused_wd = ^writedata[31:8];
  assign out_port  = out_q;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      default: seg7 = 7'h71;
    endcase
  endfunction

  // Next register state: prescaler/phase, then bus writes (mask write overrides a wrap)
  always_comb begin
    ctrl_d  = ctrl_q;
    mask_d  = mask_q;
    digit_d = digit_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (wr) begin
      if (address == ADDR_W'(0)) ctrl_d = writedata[2:0];
      if (address == ADDR_W'(1)) begin
        mask_d  = writedata[NUM_DIGITS-1:0];
        cnt_d   = '0;
        phase_d = 1'b1;
      end
      if (address == ADDR_W'(3)) begin
        for (int unsigned i = 1; i < NUM_DIGITS; i++) digit_d[i] = digit_q[i-1];
        digit_d[0] = writedata[7:0];
      end
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (address == ADDR_W'(4 + i)) digit_d[i] = writedata[7:0];
      end
    end
  end

  // Segment pattern for each digit, computed from current register contents
  always_comb begin
    logic [7:0] seg;
    out_d = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      seg = ctrl_q[1] ? {digit_q[i][7], seg7(digit_q[i][3:0])} : digit_q[i];
      if (!ctrl_q[0] || (mask_q[i] && !phase_q)) seg = '0;
      if (ctrl_q[2]) seg = ~seg;
      out_d[8*i +: 8] = seg;
    end
  end

  // Combinational read mux, zero wait states
  always_comb begin
    readdata = '0;
    if (address == ADDR_W'(0)) readdata[2:0] = ctrl_q;
    if (address == ADDR_W'(1)) readdata[NUM_DIGITS-1:0] = mask_q;
    if (address == ADDR_W'(2)) readdata[0] = phase_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (address == ADDR_W'(4 + i)) readdata[7:0] = digit_q[i];
    end
  end

  // Register update with synchronous active-low reset taking priority
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_q  <= '0;
      mask_q  <= '0;
      digit_q <= '{default: '0};
      cnt_q   <= '0;
      phase_q <= 1'b1;
      out_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      mask_q  <= mask_d;
      digit_q <= digit_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_nios_hex_bank.sv
// Self-checking bench for nios_hex_bank: directed steps followed by random bus
// traffic, compared every cycle against a behavioural model.
module tb_nios_hex_bank;

  localparam int ND = 6;
  localparam int AW = 5;
  localparam int BD = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [8*ND-1:0] out_port;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic [2:0]    m_ctrl = '0;
  logic [ND-1:0] m_mask = '0;
  logic [7:0]    m_dig [ND];
  int            m_k = 0;   // edges since reset or last BLINK_MASK write
  logic [8*ND-1:0] exp_out = '0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  nios_hex_bank #(.NUM_DIGITS(ND), .ADDR_W(AW), .BLINK_DIV(BD)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  function automatic logic m_phase();
    return ((m_k / BD) % 2) == 0;
  endfunction

  function automatic logic [8*ND-1:0] m_out();
    logic [8*ND-1:0] r;
    logic [7:0] s;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      if (m_ctrl[0] == 1'b0 || (m_mask[i] && !m_phase())) s = 8'h00;
      else if (m_ctrl[1]) s = {m_dig[i][7], seg_tab[m_dig[i][3:0]]};
      else s = m_dig[i];
      if (m_ctrl[2]) s = ~s;
      r[8*i +: 8] = s;
    end
    return r;
  endfunction

  function automatic logic [31:0] m_read(input int a);
    if (a == 0) return {29'd0, m_ctrl};
    if (a == 1) return {{(32-ND){1'b0}}, m_mask};
    if (a == 2) return {31'd0, m_phase()};
    if (a >= 4 && a < 4 + ND) return {24'd0, m_dig[a-4]};
    return 32'd0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, check outputs after it
  task automatic tick(input logic rn, input logic wr, input int a, input logic [31:0] wd);
    logic [8*ND-1:0] pend;
    reset_n = rn; chipselect = 1'b1; write_n = ~wr; address = AW'(a); writedata = wd;
    pend = m_out();
    @(posedge clk);
    if (!rn) begin
      m_ctrl = '0; m_mask = '0; m_k = 0;
      for (int i = 0; i < ND; i++) m_dig[i] = 8'h00;
      exp_out = '0;
    end else begin
      m_k++;
      exp_out = pend;
      if (wr) begin
        if (a == 0) m_ctrl = wd[2:0];
        else if (a == 1) begin m_mask = wd[ND-1:0]; m_k = 0; end
        else if (a == 3) begin
          for (int i = ND - 1; i > 0; i--) m_dig[i] = m_dig[i-1];
          m_dig[0] = wd[7:0];
        end else if (a >= 4 && a < 4 + ND) m_dig[a-4] = wd[7:0];
      end
    end
    #1;
    check("out_port", 64'(out_port), 64'(exp_out));
    check($sformatf("readdata@%0d", a), 64'(readdata), 64'(m_read(a)));
  endtask

  task automatic wr_reg(input int a, input logic [31:0] wd);
    tick(1'b1, 1'b1, a, wd);
  endtask

  task automatic idle(input int a);
    tick(1'b1, 1'b0, a, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < ND; i++) m_dig[i] = 8'h00;

    // Reset, then reads of every address
    tick(1'b0, 1'b0, 0, 32'd0);
    tick(1'b0, 1'b0, 0, 32'd0);
    check("reset_out", 64'(out_port), 64'd0);
    idle(2);
    check("reset_status", 64'(readdata), 64'd1);
    for (int a = 0; a < 32; a++) idle(a);

    // Enable only: every digit still 0
    wr_reg(0, 32'd1);
    idle(0);
    check("en_only_out", 64'(out_port), 64'd0);

    // Decode and inversion
    wr_reg(0, 32'd3);
    wr_reg(4, 32'h8A);
    wr_reg(9, 32'h03);
    idle(0);
    check("dec_d0", 64'(out_port[7:0]), 64'hF7);
    check("dec_d5", 64'(out_port[47:40]), 64'h4F);
    wr_reg(0, 32'd7);
    idle(0);
    check("inv_d0", 64'(out_port[7:0]), 64'h08);
    check("inv_d5", 64'(out_port[47:40]), 64'hB0);

    // Shift-in of seven bytes
    wr_reg(0, 32'd1);
    for (int v = 1; v <= 7; v++) wr_reg(3, 32'(v * 8'h11));
    idle(4); check("shift_d0", 64'(readdata), 64'h77);
    idle(9); check("shift_d5", 64'(readdata), 64'h22);
    idle(3); check("shift_rd0", 64'(readdata), 64'd0);
    for (int a = 4; a < 4 + ND; a++) idle(a);

    // Blinking digit 1 against steady digit 0
    wr_reg(5, 32'hFF);
    wr_reg(4, 32'h5A);
    wr_reg(1, 32'd2);
    for (int c = 0; c < 20; c++) idle(2);

    // Mask rewrite while PHASE=0 restarts the blink phase
    for (int c = 0; c < 2 * BD && m_phase(); c++) idle(2);
    check("phase0_reached", 64'(m_phase()), 64'd0);
    wr_reg(1, 32'd3);
    idle(2);
    check("mask_restart", 64'(readdata), 64'd1);
    for (int c = 0; c < 6; c++) idle(2);

    // One-cycle reset mid-blink
    tick(1'b0, 1'b0, 2, 32'd0);
    for (int a = 0; a < 10; a++) idle(a);

    // Writes to STATUS and an unmapped address are ignored
    wr_reg(0, 32'd1);
    wr_reg(6, 32'h3C);
    wr_reg(2, 32'hFFFF_FFFF);
    idle(2);
    wr_reg(15, 32'hFFFF_FFFF);
    idle(15);
    check("unmapped_rd", 64'(readdata), 64'd0);
    for (int a = 0; a < 10; a++) idle(a);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      int a;
      logic w;
      a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 9));
      w = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 99) == 0) tick(1'b0, 1'b0, a, $urandom);
      else tick(1'b1, w, a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
